// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } requester_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant selection, round-robin by default.
// Define SRAM_ARB_CPU_PRIORITY_EN for fixed CPU-first priority instead.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  requester_e i_last,
  output logic [1:0] o_grant
);

`ifdef SRAM_ARB_CPU_PRIORITY_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // One-hot grant: bit 0 = CPU, bit 1 = DMA; on a tie the port not served last wins
  always_comb begin
    o_grant = 2'b00;
    if (i_cpu_req && i_dma_req) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
      o_grant = 2'b01;
`else
      o_grant = (i_last == REQ_DMA) ? 2'b01 : 2'b10;
`endif
    end else if (i_cpu_req) begin
      o_grant = 2'b01;
    end else if (i_dma_req) begin
      o_grant = 2'b10;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter for an asynchronous SRAM with a fixed WAIT_CYCLES access window.
// Optional macro SRAM_ARB_CPU_PRIORITY_EN selects fixed CPU priority (see rr_arbiter2).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
)
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CPU_Req,
  input  logic              DMA_Req,
  input  logic              CPU_WE,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] CPU_Addr,
  input  logic [ADDR_W-1:0] DMA_Addr,
  input  logic [DATA_W-1:0] CPU_WData,
  input  logic [DATA_W-1:0] DMA_WData,
  output logic [DATA_W-1:0] CPU_RData,
  output logic [DATA_W-1:0] DMA_RData,
  output logic              CPU_Ack,
  output logic              DMA_Ack,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              Data_OE,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  requester_e        r_grant, w_grant_nxt;
  requester_e        r_last, w_last_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;
  logic              w_capture;
  logic              r_cpu_ack, r_dma_ack, w_cpu_ack_nxt, w_dma_ack_nxt;
  logic              r_mem_ce, r_mem_oe, r_mem_we, r_data_oe;
  logic              w_mem_ce_nxt, w_mem_oe_nxt, w_mem_we_nxt, w_data_oe_nxt;
  logic [1:0]        w_gnt;

  rr_arbiter2 u_arb (
    .i_cpu_req (CPU_Req),
    .i_dma_req (DMA_Req),
    .i_last    (r_last),
    .o_grant   (w_gnt)
  );

  // Next-state, latching and read-capture decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = 3'd0;
          w_grant_nxt = w_gnt[1] ? REQ_DMA : REQ_CPU;
          w_last_nxt  = w_gnt[1] ? REQ_DMA : REQ_CPU;
          w_we_nxt    = w_gnt[1] ? DMA_WE : CPU_WE;
          w_addr_nxt  = w_gnt[1] ? DMA_Addr : CPU_Addr;
          w_wdata_nxt = w_gnt[1] ? DMA_WData : CPU_WData;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 3'd0;
          w_capture   = ~r_we;
        end else begin
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // SRAM strobes and acks derived from the upcoming state so they leave a register
  always_comb begin
    w_mem_ce_nxt  = 1'b1;
    w_mem_oe_nxt  = 1'b1;
    w_mem_we_nxt  = 1'b1;
    w_data_oe_nxt = 1'b0;
    w_cpu_ack_nxt = 1'b0;
    w_dma_ack_nxt = 1'b0;
    case (w_state_nxt)
      ACCESS: begin
        w_mem_ce_nxt  = 1'b0;
        w_mem_oe_nxt  = w_we_nxt;
        w_mem_we_nxt  = ~w_we_nxt;
        w_data_oe_nxt = w_we_nxt;
      end
      DONE: begin
        // write data stays on the bus one more cycle for SRAM hold time
        w_mem_ce_nxt  = 1'b0;
        w_data_oe_nxt = w_we_nxt;
        w_cpu_ack_nxt = (w_grant_nxt == REQ_CPU);
        w_dma_ack_nxt = (w_grant_nxt == REQ_DMA);
      end
      default: begin
        w_mem_ce_nxt  = 1'b1;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_grant     <= REQ_CPU;
      r_last      <= REQ_DMA;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= 16'h0000;
      r_dma_rdata <= 16'h0000;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_mem_ce    <= 1'b1;
      r_mem_oe    <= 1'b1;
      r_mem_we    <= 1'b1;
      r_data_oe   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_cpu_ack <= w_cpu_ack_nxt;
      r_dma_ack <= w_dma_ack_nxt;
      r_mem_ce  <= w_mem_ce_nxt;
      r_mem_oe  <= w_mem_oe_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_data_oe <= w_data_oe_nxt;
      if (w_capture && (r_grant == REQ_CPU)) begin
        r_cpu_rdata <= Data_from_SRAM;
      end
      if (w_capture && (r_grant == REQ_DMA)) begin
        r_dma_rdata <= Data_from_SRAM;
      end
    end
  end

  assign CPU_RData    = r_cpu_rdata;
  assign DMA_RData    = r_dma_rdata;
  assign CPU_Ack      = r_cpu_ack;
  assign DMA_Ack      = r_dma_ack;
  assign ADDR         = r_addr;
  assign Data_to_SRAM = r_wdata;
  assign Data_OE      = r_data_oe;
  assign Mem_CE       = r_mem_ce;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;
  assign Mem_OE       = r_mem_oe;
  assign Mem_WE       = r_mem_we;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model plus directed and random traffic.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset_n, CPU_Req, DMA_Req, CPU_WE, DMA_WE;
  logic [19:0] CPU_Addr, DMA_Addr, ADDR;
  logic [15:0] CPU_WData, DMA_WData, CPU_RData, DMA_RData, Data_to_SRAM, Data_from_SRAM;
  logic        CPU_Ack, DMA_Ack, Data_OE, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  always #5 Clk = ~Clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .CPU_Req(CPU_Req), .DMA_Req(DMA_Req), .CPU_WE(CPU_WE), .DMA_WE(DMA_WE),
    .CPU_Addr(CPU_Addr), .DMA_Addr(DMA_Addr), .CPU_WData(CPU_WData), .DMA_WData(DMA_WData),
    .CPU_RData(CPU_RData), .DMA_RData(DMA_RData), .CPU_Ack(CPU_Ack), .DMA_Ack(DMA_Ack),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_OE(Data_OE), .Data_from_SRAM(Data_from_SRAM),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Transaction model: one in-flight access, k = edges since its grant
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_port = 1'b0;  // 0 = CPU, 1 = DMA
  bit          m_last = 1'b1;
  bit          m_we = 1'b0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pick_dma;
    if (!Reset_n) begin
      m_busy = 1'b0; m_k = 0; m_last = 1'b1; m_port = 1'b0;
      m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;
    end else if (m_busy) begin
      m_k++;
      if (m_k == W + 1 && !m_we) m_rd[m_port] = Data_from_SRAM;
      if (m_k == W + 2) m_busy = 1'b0;
    end else if (CPU_Req || DMA_Req) begin
      if (CPU_Req && DMA_Req) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
        pick_dma = 1'b0;
`else
        pick_dma = ~m_last;
`endif
      end else begin
        pick_dma = DMA_Req;
      end
      m_port  = pick_dma;
      m_last  = pick_dma;
      m_we    = pick_dma ? DMA_WE : CPU_WE;
      m_addr  = pick_dma ? DMA_Addr : CPU_Addr;
      m_wdata = pick_dma ? DMA_WData : CPU_WData;
      m_busy  = 1'b1;
      m_k     = 1;
    end
  endtask

  task automatic check_outputs();
    bit acc, dn;
    acc = m_busy && (m_k <= W);
    dn  = m_busy && (m_k == W + 1);
    chk("cpu_ack", 32'(CPU_Ack), 32'(dn && !m_port));
    chk("dma_ack", 32'(DMA_Ack), 32'(dn && m_port));
    chk("mem_ub", 32'(Mem_UB), 32'd0);
    chk("mem_lb", 32'(Mem_LB), 32'd0);
    chk("cpu_rdata", 32'(CPU_RData), 32'(m_rd[0]));
    chk("dma_rdata", 32'(DMA_RData), 32'(m_rd[1]));
    if (!m_busy) begin
      chk("idle_ce", 32'(Mem_CE), 32'd1);
      chk("idle_oe", 32'(Mem_OE), 32'd1);
      chk("idle_we", 32'(Mem_WE), 32'd1);
      chk("idle_doe", 32'(Data_OE), 32'd0);
    end else if (acc) begin
      chk("acc_ce", 32'(Mem_CE), 32'd0);
      chk("acc_addr", 32'(ADDR), 32'(m_addr));
      chk("acc_oe", 32'(Mem_OE), 32'(m_we));
      chk("acc_we", 32'(Mem_WE), 32'(!m_we));
      chk("acc_doe", 32'(Data_OE), 32'(m_we));
      if (m_we) chk("acc_wdata", 32'(Data_to_SRAM), 32'(m_wdata));
    end else begin
      chk("done_we", 32'(Mem_WE), 32'd1);
      if (m_we) begin
        chk("done_doe", 32'(Data_OE), 32'd1);
        chk("done_addr", 32'(ADDR), 32'(m_addr));
        chk("done_wdata", 32'(Data_to_SRAM), 32'(m_wdata));
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [19:0] a, input logic [15:0] d);
    if (p == 0) begin
      CPU_Req = rq; CPU_WE = we; CPU_Addr = a; CPU_WData = d;
    end else begin
      DMA_Req = rq; DMA_WE = we; DMA_Addr = a; DMA_WData = d;
    end
  endtask

  function automatic logic get_req(input int p);
    return (p == 0) ? CPU_Req : DMA_Req;
  endfunction

  initial begin
    int edges, cnt_a, cnt_b;
    bit got, flag, flag2;
    logic [15:0] done_d;
    int seq[$];
    int exp_seq[4];

    m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;
    Reset_n = 1'b0; Data_from_SRAM = 16'h0000;
    set_port(0, 1'b0, 1'b0, 20'h0, 16'h0);
    set_port(1, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge Clk);
    step(); step();
    Reset_n = 1'b1;
    chk("rst_cpu_rdata", 32'(CPU_RData), 32'h0000);
    chk("rst_dma_rdata", 32'(DMA_RData), 32'h0000);
    chk("rst_acks", 32'({CPU_Ack, DMA_Ack}), 32'd0);
    chk("rst_we_doe", 32'({Mem_WE, Data_OE}), 32'b10);

    // Single CPU read
    set_port(0, 1'b1, 1'b0, 20'h00010, 16'h0);
    Data_from_SRAM = 16'hBEEF;
    edges = 0; cnt_a = 0; got = 0; flag = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(); edges++;
      if (!Mem_OE) cnt_a++;
      if (DMA_Ack) flag = 1'b1;
      if (CPU_Ack) got = 1'b1;
    end
    CPU_Req = 1'b0;
    chk("rd_got_ack", 32'(got), 32'd1);
    chk("rd_latency", 32'(edges), 32'd3);
    chk("rd_oe_low", 32'(cnt_a), 32'd2);
    chk("rd_data", 32'(CPU_RData), 32'hBEEF);
    chk("rd_no_dma_ack", 32'(flag), 32'd0);
    step();

    // DMA write
    set_port(1, 1'b1, 1'b1, 20'h0ABCD, 16'h1234);
    cnt_a = 0; cnt_b = 0; got = 0; flag = 0; flag2 = 0; done_d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (!Mem_WE) begin
        cnt_a++;
        if (Data_OE && Data_to_SRAM == 16'h1234 && ADDR == 20'h0ABCD) cnt_b++;
      end
      if (DMA_Ack) begin
        got = 1'b1; flag = Mem_WE; flag2 = Data_OE; done_d = Data_to_SRAM;
      end
    end
    DMA_Req = 1'b0;
    chk("wr_got_ack", 32'(got), 32'd1);
    chk("wr_we_low", 32'(cnt_a), 32'd2);
    chk("wr_bus_ok", 32'(cnt_b), 32'd2);
    chk("wr_done_we", 32'(flag), 32'd1);
    chk("wr_done_doe", 32'(flag2), 32'd1);
    chk("wr_done_data", 32'(done_d), 32'h1234);
    step();

    // Both requesting continuously after reset
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 20'h00100, 16'h0);
    set_port(1, 1'b1, 1'b0, 20'h00200, 16'h0);
`ifdef SRAM_ARB_CPU_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      step();
      if (CPU_Ack) seq.push_back(0);
      if (DMA_Ack) seq.push_back(1);
    end
    chk("alt_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size() && i < 4; i++) chk("alt_grant", 32'(seq[i]), 32'(exp_seq[i]));
    CPU_Req = 1'b0; DMA_Req = 1'b0;
    step(); step();

    // Reset in the first ACCESS cycle of a write
    set_port(0, 1'b1, 1'b1, 20'h00005, 16'hA5A5);
    step();
    chk("abort_we_low", 32'(Mem_WE), 32'd0);
    Reset_n = 1'b0; CPU_Req = 1'b0;
    step();
    Reset_n = 1'b1;
    chk("abort_we", 32'(Mem_WE), 32'd1);
    chk("abort_doe", 32'(Data_OE), 32'd0);
    chk("abort_idle_ce", 32'(Mem_CE), 32'd1);
    flag = 0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (CPU_Ack || DMA_Ack) flag = 1'b1;
    end
    chk("abort_no_ack", 32'(flag), 32'd0);
    set_port(0, 1'b1, 1'b0, 20'h00007, 16'h0);
    Data_from_SRAM = 16'h0F0F;
    edges = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(); edges++;
      if (CPU_Ack) got = 1'b1;
    end
    CPU_Req = 1'b0;
    chk("after_abort_latency", 32'(edges), 32'd3);
    chk("after_abort_rdata", 32'(CPU_RData), 32'h0F0F);
    step();

    // Address change after grant must not reach the SRAM
    set_port(0, 1'b1, 1'b0, 20'h00001, 16'h0);
    step();
    CPU_Addr = 20'h00002;
    cnt_a = 0; got = 0;
    if (ADDR != 20'h00001) cnt_a++;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (ADDR != 20'h00001) cnt_a++;
      if (CPU_Ack) got = 1'b1;
    end
    CPU_Req = 1'b0;
    chk("hold_addr_got_ack", 32'(got), 32'd1);
    chk("hold_addr_bad", 32'(cnt_a), 32'd0);
    step();

    // Random traffic with occasional resets and post-grant input scrambling
    for (int c = 0; c < 1500; c++) begin
      bit dn_now;
      dn_now = m_busy && (m_k == W + 1);
      Data_from_SRAM = 16'($urandom);
      Reset_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (get_req(p)) begin
          if (dn_now && m_port == p[0]) begin
            set_port(p, ($urandom_range(0, 3) == 0), 1'($urandom), 20'($urandom), 16'($urandom));
          end else if (m_busy && m_k <= W && m_port == p[0] && $urandom_range(0, 3) == 0) begin
            set_port(p, 1'b1, 1'($urandom), 20'($urandom), 16'($urandom));
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_port(p, 1'b1, 1'($urandom), 20'($urandom), 16'($urandom));
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
